// File: rtl/alu_issue_stage.sv
// Single-slot operand issue/retire stage in front of a combinational ALU, owning the register file.
// Latency: 1 cycle accept->out_valid; backpressure: out_ready=0 holds the slot and drops in_ready.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int NREGS = 8,
    parameter int RADDR = $clog2(NREGS),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [RADDR-1:0] in_rd,
    input  logic [RADDR-1:0] in_rs1,
    input  logic [RADDR-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [RADDR-1:0] out_rd,
    input  logic             flush,
    input  logic [RADDR-1:0] dbg_raddr,
    output logic [WIDTH-1:0] dbg_rdata,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state_q, state_d;
    logic [2:0]       op_q;
    logic [RADDR-1:0] rd_q, rs1_q, rs2_q;
    logic [WIDTH-1:0] imm_q;
    logic             use_imm_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [CNT_W-1:0] cnt_q;

    logic accept;
    logic retire;

    assign out_valid = (state_q == S_FULL);
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready && !flush;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            state_d = S_FULL;
        end else if (retire) begin
            state_d = S_EMPTY;
        end
    end

    // Operands are read from the regfile at execute time, so a value retired
    // on the previous edge is already visible to the dependent instruction.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 3'b000;
        if (state_q == S_FULL) begin
            alu_op = op_q;
            if (rs1_q != '0) begin
                alu_a = regs_q[rs1_q];
            end
            if (use_imm_q) begin
                alu_b = imm_q;
            end else if (rs2_q != '0) begin
                alu_b = regs_q[rs2_q];
            end
        end
    end

    assign out_result  = alu_result;
    assign out_zero    = alu_zero;
    assign out_rd      = rd_q;
    assign dbg_rdata   = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];
    assign retired_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
        end else if (accept) begin
            op_q      <= in_op;
            rd_q      <= in_rd;
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            imm_q     <= in_imm;
            use_imm_q <= in_use_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (retire && (rd_q != '0)) begin
            regs_q[rd_q] <= alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage; the bench itself plays the ALU.
// A transaction-level model (pending-instruction queue + architectural regfile) predicts every output.
module tb_alu_issue_stage;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int RA = 3;
    localparam int CW = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [RA-1:0] in_rd, in_rs1, in_rs2;
    logic [W-1:0]  in_imm;
    logic          in_use_imm;
    logic [W-1:0]  alu_a, alu_b;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_result;
    logic          alu_zero;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic [RA-1:0] out_rd;
    logic          flush;
    logic [RA-1:0] dbg_raddr;
    logic [W-1:0]  dbg_rdata;
    logic [CW-1:0] retired_cnt;

    alu_issue_stage #(.WIDTH(W), .NREGS(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .flush(flush),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return a << b[4:0];
            3'b110:  return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == '0);

    typedef struct {
        logic [2:0]    op;
        logic [RA-1:0] rd, rs1, rs2;
        logic [W-1:0]  imm;
        logic          ui;
    } ins_t;

    ins_t          m_q[$];
    logic [W-1:0]  m_rf [N];
    logic [CW-1:0] m_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] obs_res, obs_a, obs_b, obs_dbg;
    logic [2:0]   obs_op;
    logic         obs_zero, obs_ov, obs_rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model before the edge, then advance the model.
    task automatic cyc(input logic v, input logic [2:0] op, input logic [RA-1:0] rd,
                       input logic [RA-1:0] rs1, input logic [RA-1:0] rs2, input logic [W-1:0] imm,
                       input logic ui, input logic ordy, input logic fl, input logic [RA-1:0] dra);
        logic         exp_rdy, exp_ov, do_ret, do_acc;
        logic [W-1:0] ea, eb, er;
        ins_t         ni;
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_use_imm = ui; out_ready = ordy; flush = fl; dbg_raddr = dra;
        #4;
        obs_res = out_result; obs_zero = out_zero; obs_a = alu_a; obs_b = alu_b;
        obs_op = alu_op; obs_dbg = dbg_rdata; obs_ov = out_valid; obs_rdy = in_ready;
        exp_ov  = (m_q.size() != 0);
        exp_rdy = !fl && (!exp_ov || ordy);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            ea = m_rf[m_q[0].rs1];
            eb = m_q[0].ui ? m_q[0].imm : m_rf[m_q[0].rs2];
            er = alu_f(m_q[0].op, ea, eb);
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
            chk("alu_op", alu_op, m_q[0].op);
            chk("out_result", out_result, er);
            chk("out_zero", out_zero, er == '0);
            chk("out_rd", out_rd, m_q[0].rd);
        end else begin
            er = '0;
            chk("alu_a_idle", alu_a, 0);
            chk("alu_b_idle", alu_b, 0);
            chk("alu_op_idle", alu_op, 0);
        end
        chk("dbg_rdata", dbg_rdata, m_rf[dra]);
        chk("retired_cnt", retired_cnt, m_cnt);
        @(posedge clk);
        do_ret = exp_ov && ordy && !fl;
        do_acc = v && exp_rdy;
        if (fl) begin
            m_q.delete();
        end else begin
            if (do_ret) begin
                if (m_q[0].rd != 0) m_rf[m_q[0].rd] = er;
                m_cnt = m_cnt + 1'b1;
                void'(m_q.pop_front());
            end
            if (do_acc) begin
                ni.op = op; ni.rd = rd; ni.rs1 = rs1; ni.rs2 = rs2; ni.imm = imm; ni.ui = ui;
                m_q.push_back(ni);
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy, input logic [RA-1:0] dra);
        cyc(1'b0, 3'b000, '0, '0, '0, '0, 1'b0, ordy, 1'b0, dra);
    endtask

    task automatic reset_seq();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_q.delete();
        for (int i = 0; i < N; i++) m_rf[i] = '0;
        m_cnt = '0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_cnt", retired_cnt, 0);
        chk("rst_alu_op", alu_op, 0);
        for (int i = 0; i < N; i++) begin
            dbg_raddr = RA'(i);
            #1;
            chk("rst_dbg", dbg_rdata, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_use_imm = 1'b0; out_ready = 1'b0; flush = 1'b0; dbg_raddr = '0;
        reset_seq();

        // Immediate load followed by a back-to-back dependent add.
        cyc(1, OP_ADD, 1, 0, 0, 32'd5, 1, 1, 0, 0);
        cyc(1, OP_ADD, 2, 1, 0, 32'd7, 1, 1, 0, 0);
        chk("t2_first", obs_res, 5);
        idle(1, 0);
        chk("t2_second", obs_res, 12);
        chk("t2_cnt", retired_cnt, 2);
        idle(1, 2);
        chk("t2_dbg_r2", obs_dbg, 12);

        // Backpressure holds the slot.
        cyc(1, OP_SUB, 3, 1, 1, 32'd0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            idle(0, 0);
            chk("t3_zero", obs_zero, 1);
            chk("t3_rdy", obs_rdy, 0);
            chk("t3_hold_a", obs_a, 5);
        end
        chk("t3_cnt_held", retired_cnt, 2);
        idle(1, 0);
        chk("t3_cnt", retired_cnt, 3);
        idle(1, 3);
        chk("t3_r3", obs_dbg, 0);

        // Flush discards the slot without writing or counting.
        cyc(1, OP_ADD, 4, 0, 0, 32'd9, 1, 1, 0, 0);
        cyc(0, OP_ADD, 0, 0, 0, 32'd0, 0, 1, 1, 0);
        idle(1, 4);
        chk("t4_ov", obs_ov, 0);
        chk("t4_r4", obs_dbg, 0);
        chk("t4_cnt", retired_cnt, 3);

        // Write to x0 retires and counts but is dropped.
        cyc(1, OP_ADD, 0, 0, 0, 32'h0000_FFFF, 1, 1, 0, 0);
        idle(1, 0);
        chk("t5_cnt", retired_cnt, 4);
        idle(1, 0);
        chk("t5_r0", obs_dbg, 0);

        // Signed compare.
        cyc(1, OP_ADD, 1, 0, 0, 32'hFFFF_FFFF, 1, 1, 0, 0);
        cyc(1, OP_ADD, 2, 0, 0, 32'd1, 1, 1, 0, 0);
        cyc(1, OP_SLT, 5, 1, 2, 32'd0, 0, 1, 0, 0);
        idle(1, 0);
        chk("t6_a", obs_a, 32'hFFFF_FFFF);
        chk("t6_b", obs_b, 1);
        chk("t6_op", obs_op, 7);
        idle(1, 5);
        chk("t6_r5", obs_dbg, 1);

        for (int k = 0; k < 600; k++) begin
            cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), RA'($urandom_range(0, N - 1)),
                RA'($urandom_range(0, N - 1)), RA'($urandom_range(0, N - 1)),
                ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 40)),
                $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, RA'($urandom_range(0, N - 1)));
        end

        // Reset while the slot is full.
        cyc(1, OP_ADD, 6, 0, 0, 32'd3, 1, 0, 0, 0);
        idle(0, 0);
        reset_seq();
        for (int k = 0; k < 50; k++) begin
            cyc($urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)), RA'($urandom_range(0, N - 1)),
                RA'($urandom_range(0, N - 1)), RA'($urandom_range(0, N - 1)), W'($urandom),
                $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0, 1'b0,
                RA'($urandom_range(0, N - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
